sprite_row_reader: RTL and testbench
====================================

# sprite_row_reader

Sprite row reader and pixel serializer that drives the 8-bit-wide sprite ROM. It sits between the VGA timing generator and the colour mapper.

- Once per scanline it computes which sprite row (if any) the line needs and reads that row from the ROM.
- It latches the row into a shift register.
- It emits one `pixel_on` bit per pixel strobe while the beam crosses the sprite, with optional horizontal mirroring and integer scaling.

## Interface

Parameters:

- SCALE, 1, horizontal and vertical pixel replication factor; legal values 1 or 2
- ROWS, 16, rows per sprite glyph; ROM address = {code, row}
- WIDTH, 8, pixels per glyph row (ROM data width)

Ports:

- Clk  input  1  system clock; one clock for the whole block
- Reset  input  1  asynchronous, active-high reset
- frame_start  input  1  one-Clk pulse at start of vertical blanking
- line_start  input  1  one-Clk pulse at start of horizontal blanking; next_y is valid in the same cycle
- next_y  input  10  scanline about to be drawn
- pix_ce  input  1  pixel strobe, one Clk wide, one per visible or blank pixel
- draw_x  input  10  current pixel column, valid when pix_ce=1
- sprite_x  input  10  left edge of sprite, sampled at frame_start
- sprite_y  input  10  top edge of sprite, sampled at frame_start
- sprite_code  input  4  glyph index, sampled at frame_start
- mirror  input  1  horizontal flip, sampled at frame_start
- rom_addr  output  8  {code[3:0], row[3:0]} to the combinational sprite ROM
- rom_data  input  8  row bitmap; bit 7 is the leftmost pixel
- pixel_on  output  1  sprite pixel opaque at the current column
- busy  output  1  high from FETCH through SHIFT

## Operation

- Attribute latching:
  - At frame_start, copy sprite_x/y/code/mirror into shadow registers.
  - All per-line decisions use the shadow copies only, so mid-frame attribute changes cannot tear the image.
- Row select: dy = next_y - y_shadow, computed as an 11-bit signed value.
  - The line hits iff 0 <= dy < ROWS*SCALE.
  - row = dy / SCALE, truncated to 4 bits.
- FSM states: IDLE, FETCH, LOAD, WAIT_X, SHIFT.
  - IDLE: on line_start with a hit, go to FETCH. On a miss, stay in IDLE with pixel_on=0.
  - FETCH: drive rom_addr={code_shadow,row}; go to LOAD next cycle.
  - LOAD: capture rom_data into row_buf, bit-reversed if mirror_shadow=1. Clear the replication counter and bit counter. Go to WAIT_X.
  - WAIT_X: on pix_ce with draw_x == x_shadow, go to SHIFT and present the first pixel in that same pix_ce cycle.
  - SHIFT: pixel_on = row_buf[7].
    - On each pix_ce, increment the replication counter.
    - When the replication counter reaches SCALE, clear it, shift row_buf left by one, and increment the bit counter.
    - After WIDTH*SCALE strobes, go to IDLE with pixel_on=0.
- Boundary conditions:
  - line_start in any state aborts the current operation and re-evaluates the new line from IDLE; this has priority over every other transition.
  - frame_start and line_start in the same cycle: shadows update first, and the line decision uses the new shadows.
  - If x_shadow + WIDTH*SCALE exceeds 639, pixels beyond the visible area are still shifted out. The timing generator blanks them; the block does not clip.
  - If x_shadow is never matched before the next line_start (e.g. x >= 800), no pixels are emitted and no error is flagged.
  - dy wrap is impossible due to the 11-bit signed compare; a sprite with y_shadow > next_y is a miss.
- rom_addr holds its last value outside FETCH. The ROM is combinational, so the value is don't-care.

## Timing

- Reset values: state=IDLE, pixel_on=0, busy=0, rom_addr=0, all shadow registers 0, row_buf=0, counters 0.
- line_start to row_buf loaded: 2 Clk (FETCH, LOAD).
  - This must complete before the first visible pix_ce. Horizontal blanking is 160 pixels, so there is ample margin.
- pixel_on is registered. It updates on the Clk edge following the pix_ce that advances it and holds steady between strobes.
- A sprite at column X is visible for exactly WIDTH*SCALE consecutive pix_ce strobes starting at draw_x==X.
- busy asserts the cycle after a hitting line_start and deasserts the cycle after the last SHIFT strobe.

## Structure

- Shared package `sprite_pkg` holds:
  - SPRITE_W=8, SPRITE_H=16, CODE_W=4
  - the FSM enum type sprite_rd_state_t
  - a function building rom_addr from code and row
- The ROM stays a separate existing module, instantiated by the parent, not inside this block.
- One sub-module is natural: `pixel_shifter` (row_buf load, mirror, replication counter, shift). The FSM and row select remain in the top module.

## Test plan

- SCALE=1, sprite_x=100, sprite_y=50, code=1, line_start with next_y=54 -> rom_addr=0x14. pixel_on over draw_x 100..107 = 1,0,1,0,0,1,0,1; 0 elsewhere.
- Same setup with mirror=1, next_y=57 (row 7 = 10111101) -> pixel_on over 100..107 = 1,0,1,1,1,1,0,1.
- next_y=49 and next_y=66 -> busy stays 0, rom_addr not driven to a new value, pixel_on=0 all line.
- SCALE=2, sprite_y=50, next_y=59 -> row 4. Each bit held for 2 strobes; pixel_on over 100..115 = 11001100 00110011.
- Change sprite_x to 200 mid-frame, then next line -> still drawn at 100. After frame_start -> drawn at 200.
- Assert Reset during SHIFT at the third pixel -> pixel_on=0 and busy=0 asynchronously, with no further pixels until the next frame_start plus a hitting line_start.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and ROM address helper for the sprite row reader.
package sprite_pkg;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 16;
    localparam int CODE_W   = 4;
    localparam int ROW_W    = 4;
    localparam int ADDR_W   = CODE_W + ROW_W;
    localparam int COORD_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_X,
        ST_SHIFT
    } sprite_rd_state_t;

    function automatic logic [ADDR_W-1:0] rom_addr_f(input logic [CODE_W-1:0] code,
                                                     input logic [ROW_W-1:0]  row);
        return {code, row};
    endfunction

endpackage

// File: rtl/pixel_shifter.sv
// Row buffer for one glyph row: optional bit-reversal on load, then MSB-first
// shift-out with each bit replicated SCALE times.
module pixel_shifter #(
    parameter int WIDTH = 8,
    parameter int SCALE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             mirror_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             step_i,
    output logic             msb_o,
    output logic             done_o
);

    localparam int REP_W = 2;
    localparam int BIT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] row_buf_q, row_buf_d, data_rev;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    always_comb begin
        data_rev = '0;
        for (int i = 0; i < WIDTH; i++) data_rev[i] = data_i[WIDTH-1-i];
    end

    always_comb begin
        row_buf_d = row_buf_q;
        rep_d     = rep_q;
        bit_d     = bit_q;
        if (load_i) begin
            row_buf_d = mirror_i ? data_rev : data_i;
            rep_d     = '0;
            bit_d     = '0;
        end else if (step_i) begin
            // The strobe that shows the last copy of a bit also moves to the next bit.
            if (rep_q == REP_W'(SCALE - 1)) begin
                rep_d     = '0;
                row_buf_d = {row_buf_q[WIDTH-2:0], 1'b0};
                bit_d     = bit_q + 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_buf_q <= '0;
            rep_q     <= '0;
            bit_q     <= '0;
        end else begin
            row_buf_q <= row_buf_d;
            rep_q     <= rep_d;
            bit_q     <= bit_d;
        end
    end

    assign msb_o  = row_buf_q[WIDTH-1];
    assign done_o = (bit_q == BIT_W'(WIDTH));

endmodule

// File: rtl/sprite_row_reader.sv
// Per-scanline sprite row fetch and pixel serializer between VGA timing and colour mapping.
module sprite_row_reader
    import sprite_pkg::*;
#(
    parameter int SCALE = 1,
    parameter int ROWS  = SPRITE_H,
    parameter int WIDTH = SPRITE_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_start_i,
    input  logic               line_start_i,
    input  logic [COORD_W-1:0] next_y_i,
    input  logic               pix_ce_i,
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] sprite_x_i,
    input  logic [COORD_W-1:0] sprite_y_i,
    input  logic [CODE_W-1:0]  sprite_code_i,
    input  logic               mirror_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [WIDTH-1:0]   rom_data_i,
    output logic               pixel_on_o,
    output logic               busy_o
);

    sprite_rd_state_t state_q, state_d;

    logic [COORD_W-1:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d;
    logic [CODE_W-1:0]  code_sh_q, code_sh_d;
    logic               mir_sh_q, mir_sh_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               pixel_on_q, pixel_on_d;

    logic [COORD_W:0]   dy;
    logic               hit;
    logic [ROW_W-1:0]   row;
    logic               sh_load, sh_step, sh_msb, sh_done;

    // Shadows bypass on frame_start so a coincident line_start sees the new attributes.
    always_comb begin
        x_sh_d    = frame_start_i ? sprite_x_i    : x_sh_q;
        y_sh_d    = frame_start_i ? sprite_y_i    : y_sh_q;
        code_sh_d = frame_start_i ? sprite_code_i : code_sh_q;
        mir_sh_d  = frame_start_i ? mirror_i      : mir_sh_q;
    end

    // Zero-extended subtraction: a sprite below the line leaves the sign bit set.
    assign dy  = {1'b0, next_y_i} - {1'b0, y_sh_d};
    assign hit = !dy[COORD_W] && (dy[COORD_W-1:0] < COORD_W'(ROWS * SCALE));
    assign row = ROW_W'(dy[COORD_W-1:0] / COORD_W'(SCALE));

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        pixel_on_d = pixel_on_q;
        sh_load    = 1'b0;
        sh_step    = 1'b0;
        if (line_start_i) begin
            pixel_on_d = 1'b0;
            if (hit) begin
                state_d    = ST_FETCH;
                rom_addr_d = rom_addr_f(code_sh_d, row);
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_LOAD;
                ST_LOAD: begin
                    sh_load = 1'b1;
                    state_d = ST_WAIT_X;
                end
                ST_WAIT_X: begin
                    if (pix_ce_i && draw_x_i == x_sh_q) begin
                        pixel_on_d = sh_msb;
                        sh_step    = 1'b1;
                        state_d    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (pix_ce_i) begin
                        if (sh_done) begin
                            pixel_on_d = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            pixel_on_d = sh_msb;
                            sh_step    = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            x_sh_q     <= '0;
            y_sh_q     <= '0;
            code_sh_q  <= '0;
            mir_sh_q   <= 1'b0;
            rom_addr_q <= '0;
            pixel_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_sh_q     <= x_sh_d;
            y_sh_q     <= y_sh_d;
            code_sh_q  <= code_sh_d;
            mir_sh_q   <= mir_sh_d;
            rom_addr_q <= rom_addr_d;
            pixel_on_q <= pixel_on_d;
        end
    end

    pixel_shifter #(.WIDTH(WIDTH), .SCALE(SCALE)) u_shifter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (sh_load),
        .mirror_i(mir_sh_q),
        .data_i  (rom_data_i),
        .step_i  (sh_step),
        .msb_o   (sh_msb),
        .done_o  (sh_done)
    );

    assign rom_addr_o = rom_addr_q;
    assign pixel_on_o = pixel_on_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sprite_row_reader.sv
// Drives SCALE=1 and SCALE=2 readers with shared stimulus; compares against a per-column sprite model.
module tb_sprite_row_reader;

    localparam int SCAN_LAST = 339;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0, line_start = 1'b0, pix_ce = 1'b0, mirror = 1'b0;
    logic [9:0] next_y = '0, draw_x = '0, sprite_x = '0, sprite_y = '0;
    logic [3:0] sprite_code = '0;
    logic [7:0] rom_addr [2];
    logic [7:0] rom_data [2];
    logic       pixel_on [2];
    logic       busy     [2];

    int n_chk = 0, n_pass = 0;

    // Model: shadows, and per instance whether the current line hits and its displayed bits.
    int         sh_x = 0, sh_y = 0, sh_code = 0;
    bit         sh_mir = 0;
    bit         hit [2];
    logic [7:0] bits [2];
    logic [7:0] last_addr [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        logic [7:0] t;
        case (a)
            8'h14:   return 8'hA5;
            8'h17:   return 8'hBD;
            default: begin t = a * 8'd37; return t ^ 8'h5A; end
        endcase
    endfunction

    assign rom_data[0] = rom_f(rom_addr[0]);
    assign rom_data[1] = rom_f(rom_addr[1]);

    sprite_row_reader #(.SCALE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .line_start_i(line_start),
        .next_y_i(next_y), .pix_ce_i(pix_ce), .draw_x_i(draw_x), .sprite_x_i(sprite_x),
        .sprite_y_i(sprite_y), .sprite_code_i(sprite_code), .mirror_i(mirror),
        .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]), .pixel_on_o(pixel_on[0]), .busy_o(busy[0]));

    sprite_row_reader #(.SCALE(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .line_start_i(line_start),
        .next_y_i(next_y), .pix_ce_i(pix_ce), .draw_x_i(draw_x), .sprite_x_i(sprite_x),
        .sprite_y_i(sprite_y), .sprite_code_i(sprite_code), .mirror_i(mirror),
        .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]), .pixel_on_o(pixel_on[1]), .busy_o(busy[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic exp_pix(input int i, input int k);
        int s = i + 1;
        if (!hit[i] || k < sh_x || k >= sh_x + 8 * s) return 1'b0;
        return bits[i][7 - (k - sh_x) / s];
    endfunction

    function automatic bit exp_busy_end(input int i);
        return hit[i] && !(sh_x + 8 * (i + 1) <= SCAN_LAST);
    endfunction

    task automatic model_line(input int ny);
        int dy, s;
        logic [3:0] rw, cd;
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            s      = i + 1;
            dy     = ny - sh_y;
            hit[i] = (dy >= 0) && (dy < 16 * s);
            if (hit[i]) begin
                rw = 4'(dy / s);
                cd = 4'(sh_code);
                last_addr[i] = {cd, rw};
                d = rom_f(last_addr[i]);
                for (int j = 0; j < 8; j++) bits[i][j] = sh_mir ? d[7-j] : d[j];
            end
        end
    endtask

    task automatic do_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        sh_x = int'(sprite_x); sh_y = int'(sprite_y); sh_code = int'(sprite_code); sh_mir = mirror;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic line_begin(input int ny, input bit fs);
        @(posedge clk); #1;
        line_start  = 1'b1;
        frame_start = fs;
        next_y      = 10'(ny);
        if (fs) begin
            sh_x = int'(sprite_x); sh_y = int'(sprite_y); sh_code = int'(sprite_code); sh_mir = mirror;
        end
        model_line(ny);
        @(posedge clk); #1;
        line_start  = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy_start s%0d y%0d", i + 1, ny), 32'(busy[i]), 32'(hit[i]));
            chk($sformatf("rom_addr s%0d y%0d", i + 1, ny), 32'(rom_addr[i]), 32'(last_addr[i]));
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic scan(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            @(posedge clk); #1;
            pix_ce = 1'b1;
            draw_x = 10'(k);
            @(posedge clk); #1;
            pix_ce = 1'b0;
            for (int i = 0; i < 2; i++)
                chk($sformatf("pix s%0d x%0d", i + 1, k), 32'(pixel_on[i]), 32'(exp_pix(i, k)));
        end
    endtask

    task automatic do_line(input int ny, input bit fs);
        line_begin(ny, fs);
        scan(0, SCAN_LAST);
        for (int i = 0; i < 2; i++)
            chk($sformatf("busy_end s%0d y%0d", i + 1, ny), 32'(busy[i]), 32'(exp_busy_end(i)));
    endtask

    initial begin
        last_addr[0] = '0; last_addr[1] = '0;
        hit[0] = 0; hit[1] = 0;
        bits[0] = '0; bits[1] = '0;
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset pixel_on", 32'(pixel_on[i]), 32'd0);
            chk("reset busy", 32'(busy[i]), 32'd0);
            chk("reset rom_addr", 32'(rom_addr[i]), 32'd0);
        end
        rst = 1'b0;

        // Directed cases from the plan
        sprite_x = 10'd100; sprite_y = 10'd50; sprite_code = 4'd1; mirror = 1'b0;
        do_frame();
        do_line(54, 0);
        mirror = 1'b1;
        do_frame();
        do_line(57, 0);
        mirror = 1'b0;
        do_frame();
        do_line(49, 0);
        do_line(66, 0);
        do_line(59, 0);
        sprite_x = 10'd200;
        do_line(54, 0);
        do_line(54, 1);

        // Asynchronous reset while shifting the third pixel
        sprite_x = 10'd100;
        do_frame();
        line_begin(54, 0);
        scan(0, 102);
        #2 rst = 1'b1;
        sh_x = 0; sh_y = 0; sh_code = 0; sh_mir = 0;
        hit[0] = 0; hit[1] = 0; last_addr[0] = '0; last_addr[1] = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_mid pixel_on", 32'(pixel_on[i]), 32'd0);
            chk("rst_mid busy", 32'(busy[i]), 32'd0);
            chk("rst_mid rom_addr", 32'(rom_addr[i]), 32'd0);
        end
        #3 rst = 1'b0;
        scan(103, SCAN_LAST);
        do_frame();
        do_line(54, 0);

        // Randomized lines with mid-frame attribute churn
        for (int n = 0; n < 24; n++) begin
            sprite_x    = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(800, 1023))
                                                      : 10'($urandom_range(0, 320));
            sprite_y    = 10'($urandom_range(0, 100));
            sprite_code = 4'($urandom_range(0, 15));
            mirror      = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: do_frame();
                1: ;
                default: ;
            endcase
            do_line($urandom_range(0, 130), 1'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
